// File: rtl/hififo_rr_arbiter.sv
// Read-request arbiter and PCIe tag manager.
// Round-robin grant among the FIFO channels feeds a one-entry request register
// toward the TX engine. Each accepted request takes the lowest free tag. Read
// completions are routed back to the tag's owning channel, and the last beat
// of a completion frees the tag.
module hififo_rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int TAGS     = 32,
    parameter int MAX_OUT  = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [CHANNELS-1:0]     req_valid,
    input  logic [64*CHANNELS-1:0]  req_addr,
    output logic [CHANNELS-1:0]     req_ready,
    output logic                    rr_valid,
    output logic [63:0]             rr_addr,
    output logic [7:0]              rr_tag,
    input  logic                    rr_ready,
    input  logic                    rc_valid,
    input  logic [7:0]              rc_tag,
    input  logic                    rc_last,
    output logic [CHANNELS-1:0]     rc_route,
    output logic [7:0]              rc_route_tag,
    output logic [8:0]              outstanding,
    output logic                    tag_error
);

    localparam int CW = $clog2(CHANNELS);
    localparam int TW = (TAGS > 1) ? $clog2(TAGS) : 1;
    localparam int NW = $clog2(MAX_OUT + 1);

    logic [TAGS-1:0]     free_q, free_d;
    logic [CW-1:0]       owner_q [TAGS];
    logic [NW-1:0]       count_q [CHANNELS];
    logic [NW-1:0]       count_d [CHANNELS];
    logic [CW-1:0]       last_grant_q;
    logic                rr_valid_q;
    logic [63:0]         rr_addr_q;
    logic [7:0]          rr_tag_q;
    logic [CHANNELS-1:0] rc_route_q, rc_route_d;
    logic [7:0]          rc_route_tag_q;
    logic [8:0]          outstanding_q, outstanding_d;
    logic                tag_error_q;

    logic                slot_open;
    logic                any_free;
    logic [CHANNELS-1:0] eligible;
    logic                grant_any;
    logic                grant_en;
    logic [CW-1:0]       grant_idx;
    logic [CW-1:0]       cand;
    logic [TW-1:0]       alloc_tag;
    logic [63:0]         sel_addr;
    logic                rc_in_range;
    logic [TW-1:0]       rc_idx;
    logic                rc_hit;
    logic                rc_free;
    logic                rc_miss;
    logic [CW-1:0]       rc_owner;

    assign slot_open   = !rr_valid_q || rr_ready;
    assign any_free    = |free_q;
    assign rc_in_range = ({1'b0, rc_tag} < 9'(TAGS));
    assign rc_idx      = rc_tag[TW-1:0];
    assign rc_owner    = owner_q[rc_idx];
    assign rc_hit      = rc_valid && rc_in_range && !free_q[rc_idx];
    assign rc_free     = rc_hit && rc_last;
    assign rc_miss     = rc_valid && !rc_hit;

    // Grant only exists while out of reset and the output register can take it.
    assign grant_en  = reset_n && slot_open && grant_any;
    assign req_ready = grant_en ? (CHANNELS'(1) << grant_idx) : '0;
    assign sel_addr  = req_addr[64*int'(grant_idx) +: 64];

    assign rr_valid     = rr_valid_q;
    assign rr_addr      = rr_addr_q;
    assign rr_tag       = rr_tag_q;
    assign rc_route     = rc_route_q;
    assign rc_route_tag = rc_route_tag_q;
    assign outstanding  = outstanding_q;
    assign tag_error    = tag_error_q;

    // A channel may be granted only with room in its quota and a free tag.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            eligible[i] = req_valid[i] && (count_q[i] < NW'(MAX_OUT)) && any_free;
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = CW'((int'(last_grant_q) + k) % CHANNELS);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Lowest-numbered free tag, taken from the bitmap before this edge's frees.
    always_comb begin
        alloc_tag = '0;
        for (int t = TAGS - 1; t >= 0; t--) begin
            if (free_q[t]) begin
                alloc_tag = TW'(t);
            end
        end
    end

    // Next-state of the free bitmap, per-channel counters and pool occupancy.
    always_comb begin
        free_d = free_q;
        if (grant_en) begin
            free_d[alloc_tag] = 1'b0;
        end
        if (rc_free) begin
            free_d[rc_idx] = 1'b1;
        end

        for (int c = 0; c < CHANNELS; c++) begin
            count_d[c] = count_q[c];
            if (grant_en && (grant_idx == CW'(c)) && !(rc_free && (rc_owner == CW'(c)))) begin
                count_d[c] = count_q[c] + NW'(1);
            end else if (rc_free && (rc_owner == CW'(c)) && !(grant_en && (grant_idx == CW'(c)))) begin
                count_d[c] = count_q[c] - NW'(1);
            end
        end

        outstanding_d = outstanding_q;
        if (grant_en && !rc_free) begin
            outstanding_d = outstanding_q + 9'd1;
        end else if (rc_free && !grant_en) begin
            outstanding_d = outstanding_q - 9'd1;
        end

        rc_route_d = rc_hit ? (CHANNELS'(1) << rc_owner) : '0;
    end

    // Owner table needs no reset: entries are only read while the tag is allocated.
    always_ff @(posedge clock) begin
        if (grant_en) begin
            owner_q[alloc_tag] <= grant_idx;
        end
    end

    // Allocation state, request register and completion routing.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            free_q         <= '1;
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c] <= '0;
            end
            last_grant_q   <= CW'(CHANNELS - 1);
            rr_valid_q     <= 1'b0;
            rr_addr_q      <= '0;
            rr_tag_q       <= '0;
            rc_route_q     <= '0;
            rc_route_tag_q <= '0;
            outstanding_q  <= '0;
            tag_error_q    <= 1'b0;
        end else begin
            free_q        <= free_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            rc_route_q    <= rc_route_d;
            tag_error_q   <= tag_error_q | rc_miss;
            if (rc_valid) begin
                rc_route_tag_q <= rc_tag;
            end
            if (grant_en) begin
                rr_valid_q   <= 1'b1;
                rr_addr_q    <= sel_addr;
                rr_tag_q     <= 8'(alloc_tag);
                last_grant_q <= grant_idx;
            end else if (rr_ready) begin
                rr_valid_q <= 1'b0;
            end
        end
    end

endmodule
